mode_selector: RTL and testbench

MODE_SELECTOR -- requirements
Module: mode_selector

---
 rtl/mode_selector.sv | 148 ++++++++++++++
 tb/tb_mode_selector.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mode_selector.sv
// Menu/mode selector: four debounced push buttons drive a two-state MENU/ACTIVE FSM.
// Define MODE_SEL_DEBOUNCE_EN to compile in the per-button debounce counter.
module mode_selector #(
   parameter int unsigned DEBOUNCE_CYCLES = 2000000,
   parameter int unsigned NUM_SONGS       = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_mode,
   input  logic       btn_song,
   input  logic       btn_confirm,
   input  logic       btn_back,
   input  logic       song_done,
   output logic [2:0] state,
   output logic [2:0] song,
   output logic       active,
   output logic       start
);

   localparam logic [2:0] MODE_FREE = 3'd0;
   localparam logic [2:0] MODE_AUTO = 3'd1;
   localparam logic [2:0] MODE_PLAY = 3'd3;
   localparam logic [2:0] MODE_SET  = 3'd4;
   localparam logic [2:0] SONG_LAST = 3'(NUM_SONGS - 1);

`ifdef MODE_SEL_DEBOUNCE_EN
   localparam bit DEB_EN = 1'b1;
`else
   localparam bit DEB_EN = 1'b0;
`endif

   typedef enum logic {MENU = 1'b0, ACTIVE = 1'b1} fsm_t;

   logic [3:0] raw_s;
   logic [3:0] sync1_q, sync2_q;
   logic [3:0] level_s;
   logic [3:0] prev_q, press_q;
   fsm_t       fsm_q;
   logic [2:0] state_q, song_q;
   logic       active_q, start_q;

   assign raw_s = {btn_back, btn_confirm, btn_song, btn_mode};

   function automatic logic [2:0] next_mode(input logic [2:0] cur);
      return (cur >= MODE_SET) ? MODE_FREE : cur + 3'd1;
   endfunction

   function automatic logic [2:0] next_song(input logic [2:0] cur);
      return (cur >= SONG_LAST) ? 3'd0 : cur + 3'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 4'b0000;
         sync2_q <= 4'b0000;
      end else begin
         sync1_q <= raw_s;
         sync2_q <= sync1_q;
      end
   end

   if (DEB_EN && (DEBOUNCE_CYCLES > 0)) begin : g_deb
      localparam int unsigned     CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
      logic [3:0]       deb_q;
      logic [CNT_W-1:0] cnt_q [4];

      // A level is accepted only after it differs from the current one for DEBOUNCE_CYCLES cycles
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            deb_q <= 4'b0000;
            for (int i = 0; i < 4; i++) cnt_q[i] <= {CNT_W{1'b0}};
         end else begin
            for (int i = 0; i < 4; i++) begin
               if (sync2_q[i] != deb_q[i]) begin
                  if (cnt_q[i] == CNT_MAX) begin
                     deb_q[i] <= sync2_q[i];
                     cnt_q[i] <= {CNT_W{1'b0}};
                  end else begin
                     cnt_q[i] <= cnt_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                  end
               end else begin
                  cnt_q[i] <= {CNT_W{1'b0}};
               end
            end
         end
      end
      assign level_s = deb_q;
   end else begin : g_nodeb
      assign level_s = sync2_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q  <= 4'b0000;
         press_q <= 4'b0000;
      end else begin
         prev_q  <= level_s;
         press_q <= level_s & ~prev_q;
      end
   end

   // Priority inside each state: back/song_done > confirm > mode > song
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q    <= MENU;
         state_q  <= MODE_FREE;
         song_q   <= 3'd0;
         active_q <= 1'b0;
         start_q  <= 1'b0;
      end else begin
         start_q <= 1'b0;
         case (fsm_q)
            MENU: begin
               if (press_q[2]) begin
                  fsm_q    <= ACTIVE;
                  active_q <= 1'b1;
                  start_q  <= 1'b1;
               end else if (press_q[0]) begin
                  state_q <= next_mode(state_q);
               end else if (press_q[1] && (state_q >= MODE_AUTO) && (state_q <= MODE_PLAY)) begin
                  song_q <= next_song(song_q);
               end else begin
                  fsm_q <= MENU;
               end
            end
            ACTIVE: begin
               if (press_q[3] || (song_done && (state_q == MODE_AUTO))) begin
                  fsm_q    <= MENU;
                  active_q <= 1'b0;
               end else begin
                  fsm_q <= ACTIVE;
               end
            end
            default: begin
               fsm_q    <= MENU;
               active_q <= 1'b0;
            end
         endcase
      end
   end

   assign state  = state_q;
   assign song   = song_q;
   assign active = active_q;
   assign start  = start_q;

endmodule

// File: tb/tb_mode_selector.sv
// Scoreboard bench for mode_selector with DEBOUNCE_CYCLES=4, NUM_SONGS=2.
module tb_mode_selector;
   localparam int DEB = 4;
   localparam int NS  = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_mode = 1'b0, btn_song = 1'b0, btn_confirm = 1'b0, btn_back = 1'b0;
   logic       song_done = 1'b0;
   logic [2:0] state, song;
   logic       active, start;

   always #5 clk = ~clk;

   mode_selector #(.DEBOUNCE_CYCLES(DEB), .NUM_SONGS(NS)) dut (
      .clk(clk), .rst_n(rst_n),
      .btn_mode(btn_mode), .btn_song(btn_song), .btn_confirm(btn_confirm), .btn_back(btn_back),
      .song_done(song_done),
      .state(state), .song(song), .active(active), .start(start)
   );

   typedef struct { int st; int sg; int act; } exp_t;
   exp_t sb_q[$];

   int vectors = 0, miscompares = 0;
   int m_state = 0, m_song = 0, m_active = 0, exp_starts = 0;
   int starts = 0, run = 0, max_run = 0;
   logic start_prev = 1'b0;

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      if (obs != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   // start pulse counting and width tracking
   always @(negedge clk) begin
      if (start) begin
         run++;
         if (!start_prev) starts++;
      end else begin
         run = 0;
      end
      if (run > max_run) max_run = run;
      start_prev = start;
   end

   // mask bits: 0 mode, 1 song, 2 confirm, 3 back
   task automatic model_event(input logic [3:0] mask, input logic done);
      if (m_active != 0) begin
         if (mask[3] || (done && m_state == 1)) m_active = 0;
      end else if (mask[2]) begin
         m_active = 1;
         exp_starts++;
      end else if (mask[0]) begin
         m_state = (m_state == 4) ? 0 : m_state + 1;
      end else if (mask[1] && m_state >= 1 && m_state <= 3) begin
         m_song = (m_song == NS - 1) ? 0 : m_song + 1;
      end
   endtask

   task automatic push_exp();
      exp_t e;
      e.st = m_state; e.sg = m_song; e.act = m_active;
      sb_q.push_back(e);
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      vectors++;
      if (sb_q.size() == 0) begin
         miscompares++;
         $display("FAIL %s: scoreboard empty, got state=%0d", tag, state);
         return;
      end
      vectors--;
      e = sb_q.pop_front();
      check({tag, ".state"}, int'(state), e.st);
      check({tag, ".song"}, int'(song), e.sg);
      check({tag, ".active"}, int'(active), e.act);
   endtask

   task automatic drive(input string tag, input logic [3:0] mask, input int hold);
      @(negedge clk);
      {btn_back, btn_confirm, btn_song, btn_mode} = mask;
      model_event(mask, 1'b0);
      push_exp();
      repeat (hold) @(negedge clk);
      {btn_back, btn_confirm, btn_song, btn_mode} = 4'b0000;
      repeat (14) @(negedge clk);
      pop_check(tag);
   endtask

   task automatic pulse_done(input string tag);
      @(negedge clk);
      song_done = 1'b1;
      model_event(4'b0000, 1'b1);
      push_exp();
      @(negedge clk);
      song_done = 1'b0;
      repeat (3) @(negedge clk);
      pop_check(tag);
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached, got vectors=%0d", vectors);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst.state", int'(state), 0);
      check("rst.song", int'(song), 0);
      check("rst.active", int'(active), 0);
      check("rst.start", int'(start), 0);
      #3 rst_n = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 5; i++) drive($sformatf("mode%0d", i), 4'b0001, 12);

      drive("to_auto", 4'b0001, 12);
      for (int i = 0; i < 3; i++) drive($sformatf("song%0d", i), 4'b0010, 12);
      for (int i = 0; i < 4; i++) drive($sformatf("to_free%0d", i), 4'b0001, 12);
      drive("song_in_free", 4'b0010, 12);

`ifdef MODE_SEL_DEBOUNCE_EN
      @(negedge clk);
      btn_mode = 1'b1;
      push_exp();
      repeat (2) @(negedge clk);
      btn_mode = 1'b0;
      repeat (20) @(negedge clk);
      pop_check("glitch");
`endif
      drive("hold10", 4'b0001, 10);

      drive("confirm_auto", 4'b0100, 12);
      check("start_cnt1", starts, exp_starts);
      pulse_done("done_auto");

      drive("to_stdy", 4'b0001, 12);
      drive("to_play", 4'b0001, 12);
      drive("confirm_play", 4'b0100, 12);
      pulse_done("done_play_ignored");
      drive("mode_in_active", 4'b0001, 12);
      drive("song_in_active", 4'b0010, 12);
      drive("back_confirm", 4'b1100, 12);
      check("start_cnt2", starts, exp_starts);
      pulse_done("done_in_menu");

      drive("confirm_play2", 4'b0100, 12);
      @(negedge clk);
      btn_mode = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      m_state = 0; m_song = 0; m_active = 0;
      #1;
      check("midrst.state", int'(state), m_state);
      check("midrst.song", int'(song), m_song);
      check("midrst.active", int'(active), m_active);
      check("midrst.start", int'(start), 0);
      btn_mode = 1'b0;
      repeat (3) @(negedge clk);
      #3 rst_n = 1'b1;
      push_exp();
      repeat (20) @(negedge clk);
      pop_check("post_rst");

      check("start_cnt_final", starts, exp_starts);
      check("start_width", max_run, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
